keypad_event_decoder: RTL and testbench

KEYPAD_EVENT_DECODER -- requirements
Module: keypad_event_decoder

---
 rtl/keypad_event_decoder.sv | 175 +++++++++++++++++
 tb/tb_keypad_event_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_decoder.sv
// Keypad event decoder: debounces sticky scanner key codes and emits one event per press.
// Define KEY_EVENT_FIFO_EN for a 4-entry first-word-fall-through event FIFO; otherwise one output register.
module keypad_event_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 200,
    parameter int unsigned RELEASE_CYCLES  = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code,
    input  logic [3:0] col_n,
    output logic       ev_valid,
    output logic [3:0] ev_key,
    input  logic       ev_ready,
    output logic       key_held,
    output logic       overflow
);
`ifdef KEY_EVENT_FIFO_EN
    localparam int unsigned DEPTH = 4;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]       cand_q, cand_d;
    logic [3:0]       slot_q [DEPTH];
    logic [3:0]       slot_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic             held_q, held_d;
    logic             ovf_q, ovf_d;

    logic code_ok, col_active, released, push, pop, full, placed;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Key index = row*4 + col, with bit7 = row0 and bit3 = col0.
    function automatic logic [3:0] key_index(input logic [7:0] code);
        logic [1:0] row;
        logic [1:0] col;
        unique case (code[7:4])
            4'b0100: row = 2'd1;
            4'b0010: row = 2'd2;
            4'b0001: row = 2'd3;
            default: row = 2'd0;
        endcase
        unique case (code[3:0])
            4'b0100: col = 2'd1;
            4'b0010: col = 2'd2;
            4'b0001: col = 2'd3;
            default: col = 2'd0;
        endcase
        return {row, col};
    endfunction

    // Press/release FSM plus idle-column release counter.
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        cand_d     = cand_q;
        push       = 1'b0;
        code_ok    = is_onehot4(key_code[7:4]) && is_onehot4(key_code[3:0]);
        col_active = (col_n != 4'hF);
        released   = (idle_cnt_q == CNT_W'(RELEASE_CYCLES));
        idle_cnt_d = col_active ? '0 : (released ? idle_cnt_q : idle_cnt_q + CNT_W'(1));

        unique case (state_q)
            IDLE: begin
                if (col_active && code_ok) begin
                    cand_d   = key_code;
                    db_cnt_d = CNT_W'(1);
                    if (DEBOUNCE_CYCLES == 32'd1) begin
                        push    = 1'b1;
                        state_d = PRESSED;
                    end else begin
                        state_d = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (!code_ok || (key_code != cand_q) || released) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                    if (db_cnt_d == CNT_W'(DEBOUNCE_CYCLES)) begin
                        push    = 1'b1;
                        state_d = PRESSED;
                    end
                end
            end
            PRESSED: begin
                if (released) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (code_ok && (key_code != cand_q)) begin
                    // Rollover to a new key restarts the debounce on it.
                    cand_d   = key_code;
                    db_cnt_d = CNT_W'(1);
                    if (DEBOUNCE_CYCLES == 32'd1) begin
                        push = 1'b1;
                    end else begin
                        state_d = DEBOUNCE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
            end
        endcase

        held_d = (state_d == PRESSED);
    end

    // Shift-register event storage: slot 0 is the head presented on ev_key.
    always_comb begin
        slot_d = slot_q;
        vld_d  = vld_q;
        pop    = vld_q[0] && ev_ready;
        full   = vld_q[DEPTH-1];
        placed = 1'b0;
        if (pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                slot_d[i] = slot_q[i+1];
                vld_d[i]  = vld_q[i+1];
            end
            slot_d[DEPTH-1] = '0;
            vld_d[DEPTH-1]  = 1'b0;
        end
        ovf_d = push && full && !pop;
        if (push && !ovf_d) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!vld_d[i] && !placed) begin
                    slot_d[i] = key_index(cand_d);
                    vld_d[i]  = 1'b1;
                    placed    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            idle_cnt_q <= '0;
            cand_q     <= '0;
            slot_q     <= '{default: '0};
            vld_q      <= '0;
            held_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            cand_q     <= cand_d;
            slot_q     <= slot_d;
            vld_q      <= vld_d;
            held_q     <= held_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ev_valid = vld_q[0];
    assign ev_key   = slot_q[0];
    assign key_held = held_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_event_decoder.sv
// Bench for keypad_event_decoder: directed press scenarios plus random traffic against a queue-based model.
module tb_keypad_event_decoder;
    localparam int DCYC = 4;
    localparam int RCYC = 8;
`ifdef KEY_EVENT_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] key_code;
    logic [3:0] col_n;
    logic       ev_valid;
    logic [3:0] ev_key;
    logic       ev_ready;
    logic       key_held;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    keypad_event_decoder #(.DEBOUNCE_CYCLES(DCYC), .RELEASE_CYCLES(RCYC)) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .col_n(col_n),
        .ev_valid(ev_valid), .ev_key(ev_key), .ev_ready(ev_ready),
        .key_held(key_held), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit valid_code(input logic [7:0] kc);
        return ($countones(kc[7:4]) == 1) && ($countones(kc[3:0]) == 1);
    endfunction

    function automatic int idx_of(input logic [7:0] kc);
        int row = 0;
        int col = 0;
        for (int i = 0; i < 4; i++) begin
            if (kc[7-i]) row = i;
            if (kc[3-i]) col = i;
        end
        return row * 4 + col;
    endfunction

    function automatic logic [7:0] code_of(input int k);
        logic [7:0] r;
        logic [7:0] c;
        r = 8'h80 >> (k / 4);
        c = 8'h08 >> (k % 4);
        return r | c;
    endfunction

    // Reference model: phase 0 idle, 1 debouncing, 2 held; events kept in a queue.
    int         m_phase = 0;
    int         m_db    = 0;
    int         m_idle  = 0;
    logic [7:0] m_cand  = 8'h00;
    bit         m_ovf   = 1'b0;
    bit         m_push, m_rel, m_ok;
    int         q[$];
    bit         live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_db = 0; m_idle = 0; m_cand = 8'h00; m_ovf = 1'b0;
            q.delete();
            live = 1'b1;
        end else begin
            m_rel  = (m_idle == RCYC);
            m_ok   = valid_code(key_code);
            m_push = 1'b0;
            if (m_phase == 0) begin
                if (col_n != 4'hF && m_ok) begin
                    m_cand = key_code; m_db = 1;
                    if (m_db >= DCYC) begin m_push = 1'b1; m_phase = 2; end
                    else m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (!m_ok || key_code != m_cand || m_rel) begin
                    m_phase = 0; m_db = 0;
                end else begin
                    m_db++;
                    if (m_db == DCYC) begin m_push = 1'b1; m_phase = 2; end
                end
            end else begin
                if (m_rel) begin
                    m_phase = 0; m_db = 0;
                end else if (m_ok && key_code != m_cand) begin
                    m_cand = key_code; m_db = 1;
                    if (DCYC == 1) m_push = 1'b1;
                    else m_phase = 1;
                end
            end
            if (q.size() != 0 && ev_ready) void'(q.pop_front());
            m_ovf = 1'b0;
            if (m_push) begin
                if (q.size() < DEPTH) q.push_back(idx_of(m_cand));
                else m_ovf = 1'b1;
            end
            m_idle = (col_n == 4'hF) ? ((m_idle < RCYC) ? m_idle + 1 : RCYC) : 0;
        end
    end

    // Accepted transfers and overflow pulses seen at the DUT boundary.
    int got[$];
    int ovf_seen = 0;
    always @(posedge clk) begin
        if (!rst && ev_valid === 1'b1 && ev_ready === 1'b1) got.push_back(int'(ev_key));
    end

    always @(negedge clk) begin
        if (live) begin
            chk("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("ev_key", 32'(ev_key), 32'(q[0]));
            chk("key_held", 32'(key_held), 32'(m_phase == 2));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (overflow === 1'b1) ovf_seen++;
        end
    end

    task automatic wait_rise(input int max_n, output int n);
        n = max_n + 1;
        for (int i = 1; i <= max_n; i++) begin
            @(negedge clk);
            if (ev_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic idle_for(input int n);
        col_n = 4'hF;
        repeat (n) @(negedge clk);
    endtask

    task automatic press_for(input int k, input int n);
        key_code = code_of(k);
        col_n    = ~key_code[3:0];
        repeat (n) @(negedge clk);
    endtask

    int n;
    bit press_mode;
    int ovf_base;

    initial begin
        rst = 1'b1; key_code = 8'h00; col_n = 4'hF; ev_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ev_valid", 32'(ev_valid), 32'd0);
        chk("rst_ev_key", 32'(ev_key), 32'd0);
        chk("rst_key_held", 32'(key_held), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Single held key: one event, index 9, four matching samples.
        ev_ready = 1'b1; key_code = 8'b0010_0100; col_n = 4'b1101;
        wait_rise(10, n);
        chk("press_latency", 32'(n), 32'd4);
        chk("press_key", 32'(ev_key), 32'd9);
        repeat (16) @(negedge clk);
        chk("press_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("press_got_key", 32'(got[0]), 32'd9);
        chk("press_held", 32'(key_held), 32'd1);

        idle_for(10);
        chk("release_held", 32'(key_held), 32'd0);

        // Bouncing between two keys never settles.
        got.delete();
        col_n = 4'b1011;
        for (int r = 0; r < 4; r++) begin
            key_code = 8'h84; repeat (2) @(negedge clk);
            key_code = 8'h42; repeat (2) @(negedge clk);
        end
        chk("bounce_none", 32'(got.size()), 32'd0);
        repeat (10) @(negedge clk);
        chk("bounce_settle_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("bounce_settle_key", 32'(got[0]), 32'(idx_of(8'h42)));

        // Release then re-press the same key gives a second event.
        idle_for(10);
        chk("repress_released", 32'(key_held), 32'd0);
        col_n = 4'b1011;
        repeat (10) @(negedge clk);
        chk("repress_count", 32'(got.size()), 32'd2);

        // Reset mid-debounce discards the partial press.
        idle_for(10);
        got.delete();
        key_code = code_of(9); col_n = 4'b1101;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(ev_valid), 32'd0);
        chk("midrst_held", 32'(key_held), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        wait_rise(10, n);
        chk("midrst_latency", 32'(n), 32'd4);
        repeat (4) @(negedge clk);
        chk("midrst_count", 32'(got.size()), 32'd1);

        // Storage full behaviour with a stalled consumer.
        idle_for(10);
        got.delete();
        ev_ready = 1'b0;
        ovf_base = ovf_seen;
`ifdef KEY_EVENT_FIFO_EN
        press_for(0, 6); idle_for(10);
        press_for(5, 6); idle_for(10);
        press_for(10, 6); idle_for(10);
        press_for(15, 6); idle_for(10);
        chk("fifo_no_ovf_yet", 32'(ovf_seen - ovf_base), 32'd0);
        press_for(1, 6); idle_for(10);
        chk("fifo_ovf_once", 32'(ovf_seen - ovf_base), 32'd1);
        chk("fifo_head", 32'(ev_key), 32'd0);
        ev_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("fifo_drain_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk("fifo_drain0", 32'(got[0]), 32'd0);
            chk("fifo_drain1", 32'(got[1]), 32'd5);
            chk("fifo_drain2", 32'(got[2]), 32'd10);
            chk("fifo_drain3", 32'(got[3]), 32'd15);
        end
`else
        press_for(3, 6); idle_for(10);
        press_for(12, 6); idle_for(10);
        chk("reg_ovf_once", 32'(ovf_seen - ovf_base), 32'd1);
        chk("reg_key_kept", 32'(ev_key), 32'd3);
        chk("reg_valid_kept", 32'(ev_valid), 32'd1);
        ev_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("reg_drain_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("reg_drain_key", 32'(got[0]), 32'd3);
`endif

        // Random traffic, checked each cycle against the model.
        press_mode = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0)
                key_code = ($urandom_range(0, 99) < 85) ? code_of(int'($urandom_range(0, 15)))
                                                        : 8'($urandom());
            if ($urandom_range(0, 11) == 0) press_mode = ~press_mode;
            if (press_mode && $urandom_range(0, 3) != 0)
                col_n = 4'hF & ~(4'b0001 << $urandom_range(0, 3));
            else
                col_n = 4'hF;
            if ($urandom_range(0, 7) == 0) ev_ready = ~ev_ready;
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
